// File: rtl/alu_reservation_station.sv
// Reservation station feeding the ALU: buffers issued ops, resolves operand tags from the
// ALU/LSB common data buses, and dispatches the lowest-index ready op each cycle.
module alu_reservation_station #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 5,
    parameter int OP_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [OP_W-1:0]  issue_op,
    input  logic [TAG_W-1:0] issue_entry,
    input  logic [31:0]      issue_pc,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    output logic             rs_full,
    input  logic             cdb_alu_valid,
    input  logic [TAG_W-1:0] cdb_alu_entry,
    input  logic [31:0]      cdb_alu_value,
    input  logic             cdb_lsb_valid,
    input  logic [TAG_W-1:0] cdb_lsb_entry,
    input  logic [31:0]      cdb_lsb_value,
    output logic             alu_valid,
    output logic [OP_W-1:0]  alu_op,
    output logic [31:0]      alu_vj,
    output logic [31:0]      alu_vk,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [TAG_W-1:0] alu_entry
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] ready;
    logic [OP_W-1:0]    op_q    [RS_SIZE];
    logic [TAG_W-1:0]   entry_q [RS_SIZE];
    logic [31:0]        pc_q    [RS_SIZE];
    logic [31:0]        imm_q   [RS_SIZE];
    logic [31:0]        vj_q    [RS_SIZE];
    logic [31:0]        vk_q    [RS_SIZE];
    logic [TAG_W-1:0]   qj_q    [RS_SIZE];
    logic [TAG_W-1:0]   qk_q    [RS_SIZE];

    logic               disp_hit;
    logic [IDX_W-1:0]   disp_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               issue_ok;
    logic [TAG_W-1:0]   new_qj, new_qk;
    logic [31:0]        new_vj, new_vk;

    // Tag 0 means "value present", so a zero tag never matches a broadcast.
    function automatic logic [TAG_W+31:0] resolve(
        input logic [TAG_W-1:0] q,
        input logic [31:0]      v,
        input logic             a_valid,
        input logic [TAG_W-1:0] a_tag,
        input logic [31:0]      a_value,
        input logic             l_valid,
        input logic [TAG_W-1:0] l_tag,
        input logic [31:0]      l_value
    );
        logic [TAG_W+31:0] r;
        r = {q, v};
        if (q != '0) begin
            if (a_valid && a_tag == q)      r = {{TAG_W{1'b0}}, a_value};
            else if (l_valid && l_tag == q) r = {{TAG_W{1'b0}}, l_value};
        end
        return r;
    endfunction

    always_comb begin
        ready    = '0;
        disp_hit = 1'b0;
        disp_idx = '0;
        free_idx = '0;
        for (int i = 0; i < RS_SIZE; i++)
            ready[i] = busy[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                disp_hit = 1'b1;
                disp_idx = IDX_W'(i);
            end
            if (!busy[i]) free_idx = IDX_W'(i);
        end
    end

    assign rs_full  = &busy;
    assign issue_ok = issue_valid && !rs_full;

    always_comb begin
        {new_qj, new_vj} = resolve(issue_qj, issue_vj, cdb_alu_valid, cdb_alu_entry, cdb_alu_value,
                                   cdb_lsb_valid, cdb_lsb_entry, cdb_lsb_value);
        {new_qk, new_vk} = resolve(issue_qk, issue_vk, cdb_alu_valid, cdb_alu_entry, cdb_alu_value,
                                   cdb_lsb_valid, cdb_lsb_entry, cdb_lsb_value);
    end

    // Payload needs no reset: it is only observed through a set busy bit.
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    {qj_q[i], vj_q[i]} <= resolve(qj_q[i], vj_q[i], cdb_alu_valid, cdb_alu_entry,
                        cdb_alu_value, cdb_lsb_valid, cdb_lsb_entry, cdb_lsb_value);
                    {qk_q[i], vk_q[i]} <= resolve(qk_q[i], vk_q[i], cdb_alu_valid, cdb_alu_entry,
                        cdb_alu_value, cdb_lsb_valid, cdb_lsb_entry, cdb_lsb_value);
                end
            end
            if (issue_ok) begin
                op_q[free_idx]    <= issue_op;
                entry_q[free_idx] <= issue_entry;
                pc_q[free_idx]    <= issue_pc;
                imm_q[free_idx]   <= issue_imm;
                vj_q[free_idx]    <= new_vj;
                vk_q[free_idx]    <= new_vk;
                qj_q[free_idx]    <= new_qj;
                qk_q[free_idx]    <= new_qk;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            alu_valid <= 1'b0;
            alu_op    <= '0;
            alu_vj    <= '0;
            alu_vk    <= '0;
            alu_imm   <= '0;
            alu_pc    <= '0;
            alu_entry <= '0;
        end else if (rdy) begin
            if (flush) begin
                busy      <= '0;
                alu_valid <= 1'b0;
            end else begin
                alu_valid <= disp_hit;
                if (disp_hit) begin
                    alu_op           <= op_q[disp_idx];
                    alu_vj           <= vj_q[disp_idx];
                    alu_vk           <= vk_q[disp_idx];
                    alu_imm          <= imm_q[disp_idx];
                    alu_pc           <= pc_q[disp_idx];
                    alu_entry        <= entry_q[disp_idx];
                    busy[disp_idx]   <= 1'b0;
                end
                // The dispatched slot is busy pre-edge, so it never collides with free_idx.
                if (issue_ok) busy[free_idx] <= 1'b1;
            end
        end
    end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station for non-load/store instructions; sits directly downstream of the issue stage.
- Buffers issued ops with their Vj/Vk/Qj/Qk operands and snoops the two CDB ports (ALU and LSB) to resolve pending tags.
- Dispatches one fully-ready op per cycle to the ALU.
- Cleared on ROB flush (misprediction).

Parameters:
- RS_SIZE, 8, number of station entries (power of 2, 2..16).
- TAG_W, 5, ROB tag width; tag value 0 reserved as "operand ready", valid ROB entries 1..2^TAG_W-1.
- OP_W, 6, opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  ROB clear; discard all entries.
- issue_valid  in  1  issue presents an RS op (is_rs).
- issue_op  in  OP_W  decoded opcode.
- issue_entry  in  TAG_W  destination ROB tag.
- issue_pc  in  32  instruction PC.
- issue_imm  in  32  immediate.
- issue_vj / issue_vk  in  32  operand values from regfile.
- issue_qj / issue_qk  in  TAG_W  producer tags, 0 = value valid.
- rs_full  out  1  no free entry this cycle.
- cdb_alu_valid  in  1  ALU broadcast valid.
- cdb_alu_entry  in  TAG_W  ALU result tag.
- cdb_alu_value  in  32  ALU result.
- cdb_lsb_valid  in  1  LSB broadcast valid.
- cdb_lsb_entry  in  TAG_W  LSB result tag.
- cdb_lsb_value  in  32  LSB result.
- alu_valid  out  1  dispatch strobe, one cycle per op.
- alu_op  out  OP_W  opcode.
- alu_vj / alu_vk  out  32  resolved operands.
- alu_imm / alu_pc  out  32  immediate, PC.
- alu_entry  out  TAG_W  destination ROB tag.

Behaviour:
- Reset (async): all busy bits 0; alu_valid 0; all alu_* data outputs 0; rs_full 0.
- Entry state: busy, op, entry, pc, imm, vj, vk, qj, qk. Ready = busy && qj==0 && qk==0.
- rs_full is combinational: all busy bits set (current registered state). Upstream does not assert issue_valid when rs_full=1; if it does, the op is dropped and state is unchanged.
- Issue (rdy && issue_valid && !rs_full && !flush): write the lowest-index free entry at the edge.
- Issue bypass: if a CDB port broadcasts a tag equal to issue_qj (nonzero) in the same cycle, store that value in vj and qj=0. Same rule for qk. ALU port and LSB port are checked independently.
- CDB snoop each rdy cycle: every busy entry with qj==cdb_x_entry (nonzero, valid) loads vj and clears qj. Same for qk. Both ports are applied in the same cycle.
- Dispatch at each rdy edge: select the lowest-index entry that is ready in the pre-edge state.
  - Register its fields onto alu_*, set alu_valid=1, clear its busy bit.
  - If no entry is ready, alu_valid=0 and alu_* data holds its previous value.
- Latency: an op issued at edge N with both operands ready dispatches at edge N+1 (alu_valid high during cycle N+1). An operand resolved by CDB at edge M makes the entry eligible at edge M+1.
- Entries selected for dispatch in a cycle are not updated by CDB; their operands were already resolved.
- Same-cycle issue and dispatch are allowed. A slot freed by dispatch is reusable from the next cycle (rs_full reflects pre-edge state).
- rdy=0: no state changes, outputs held; the ALU is frozen by the same rdy.
- flush (sync, with rdy): clear all busy bits, alu_valid=0. Flush overrides issue, CDB and dispatch in that cycle.
- Reset mid-operation: immediate return to reset state, pending entries lost.

Test Plan:
- Reset, then issue op=ADD entry=3 qj=qk=0 vj=5 vk=7 at edge 1 -> alu_valid=1 in cycle after edge 2 with alu_entry=3, alu_vj=5, alu_vk=7; single-cycle pulse.
- Issue entry=4 qj=2 vk ready; hold 3 cycles -> no dispatch. Then cdb_alu_valid=1 entry=2 value=0x10 -> next edge dispatches with alu_vj=0x10.
- Issue entry=6 qk=9 while cdb_lsb_valid=1 entry=9 value=0xABCD in the same cycle -> entry stored with vk=0xABCD, dispatches on the following edge.
- Fill all 8 entries with qj=1 -> rs_full=1; an extra issue is ignored. Broadcast tag 1 -> entries dispatch one per cycle in index order 0..7; rs_full falls after the first dispatch.
- Three waiting entries plus flush while cdb_alu_valid matches their tag -> all busy bits cleared, no alu_valid pulse, rs_full=0.
- Ready entry present, rdy low for 3 cycles -> outputs and state held. On rdy high, dispatch proceeds exactly once.
